// File: rtl/spi_slave_if.sv
// SPI responder bus: serial pins plus the TX holding-register handshake and RX word strobe.
// The slave modport is the responder's view; the master modport is the SoC/bench view.
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, busy
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI responder, MSB first, with oversampled SPI pins and a one-word TX holding register.
// miso follows sck fall by ~SYNC_STAGES+2 clk; rx_valid follows the last sck rise by SYNC_STAGES+2 clk.
module spi_slave #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = 8'hFF
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);
  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              rise_seen_q, rise_seen_d;
  logic              word_done_q, word_done_d;
  logic              idle_word_q, idle_word_d;
  logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_pend_q, rx_pend_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rx_word;

  assign load_word = hold_full_q ? hold_q : TX_IDLE;
  assign rx_word   = {shift_rx_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rise_seen_d = rise_seen_q;
    word_done_d = word_done_q;
    idle_word_d = idle_word_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    underrun_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_pend_d   = 1'b0;
    rx_valid_d  = rx_pend_q;

    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (cs_rise) begin
      state_d     = ST_IDLE;
      oe_d        = 1'b0;
      miso_d      = 1'b0;
      bit_cnt_d   = '0;
      rise_seen_d = 1'b0;
      word_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_LOAD;
        ST_LOAD: begin
          // A write landing now only sees an empty register, so it waits for the next word.
          if (hold_full_q) hold_full_d = 1'b0;
          shift_tx_d  = load_word;
          idle_word_d = ~hold_full_q;
          miso_d      = load_word[DATA_W-1];
          oe_d        = 1'b1;
          bit_cnt_d   = '0;
          rise_seen_d = 1'b0;
          word_done_d = 1'b0;
          state_d     = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            // Underrun is flagged at the word's first rise so a trailing reload before cs_rise stays silent.
            underrun_d  = idle_word_q & ~rise_seen_q;
            rise_seen_d = 1'b1;
            shift_rx_d  = rx_word;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d   = rx_word;
              rx_pend_d   = 1'b1;
              bit_cnt_d   = '0;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (sck_fall && rise_seen_q) begin
            if (word_done_q) begin
              state_d = ST_LOAD;
            end else begin
              shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
              miso_d     = shift_tx_q[DATA_W-2];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rise_seen_q <= 1'b0;
      word_done_q <= 1'b0;
      idle_word_q <= 1'b0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_pend_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rise_seen_q <= rise_seen_d;
      word_done_q <= word_done_d;
      idle_word_q <= idle_word_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      underrun_q  <= underrun_d;
      rx_data_q   <= rx_data_d;
      rx_pend_q   <= rx_pend_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state_q != ST_IDLE);
endmodule
